// File: rtl/muldiv_pkg.sv
// Shared types and sizing for the iterative multiply/divide unit.
package muldiv_pkg;

  localparam int MD_WIDTH = 32;
  localparam int CNT_W    = $clog2(MD_WIDTH) + 1;

  typedef enum logic [1:0] {
    OP_MULT  = 2'd0,
    OP_MULTU = 2'd1,
    OP_DIV   = 2'd2,
    OP_DIVU  = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_FIX
  } state_e;

  function automatic logic op_is_signed(input op_e op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/muldiv_signfix.sv
// Sign correction of the unsigned-magnitude mul/div result into final {hi,lo}.
module muldiv_signfix
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic [2*WIDTH-1:0] i_raw,
  input  op_e                i_op,
  input  logic               i_neg_res,
  input  logic               i_neg_rem,
  output logic [WIDTH-1:0]   o_hi,
  output logic [WIDTH-1:0]   o_lo
);

  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_rem;
  logic [WIDTH-1:0]   w_quo;

  assign w_prod = i_neg_res ? -i_raw : i_raw;
  assign w_rem  = i_raw[2*WIDTH-1:WIDTH];
  assign w_quo  = i_raw[WIDTH-1:0];

  // Divide packs {remainder, quotient}; each half carries its own sign rule.
  always_comb begin
    o_hi = w_prod[2*WIDTH-1:WIDTH];
    o_lo = w_prod[WIDTH-1:0];
    if (i_op == OP_DIV || i_op == OP_DIVU) begin
      o_hi = i_neg_rem ? -w_rem : w_rem;
      o_lo = i_neg_res ? -w_quo : w_quo;
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer owning HI/LO, one step per cycle.
// Optional MULDIV_EARLY_EXIT_EN lets multiplies finish once the multiplier is exhausted.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  state_e             r_state;
  state_e             w_next;
  op_e                r_op;
  logic [CNT_W-1:0]   r_cnt;
  logic [2*WIDTH-1:0] r_acc;
  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [WIDTH-1:0]   r_rem;
  logic [WIDTH-1:0]   r_quo;
  logic [WIDTH-1:0]   r_divisor;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_neg_res;
  logic               r_neg_rem;

  logic               w_sa;
  logic               w_sb;
  logic               w_iter_done;
  logic               w_mul_zero;
  logic               w_trial_ok;
  logic [WIDTH-1:0]   w_abs_a;
  logic [WIDTH-1:0]   w_abs_b;
  logic [WIDTH:0]     w_shift;
  logic [WIDTH:0]     w_diff;
  logic [2*WIDTH-1:0] w_raw;
  logic [WIDTH-1:0]   w_fix_hi;
  logic [WIDTH-1:0]   w_fix_lo;

  assign w_sa    = op_is_signed(op_e'(op)) & a[WIDTH-1];
  assign w_sb    = op_is_signed(op_e'(op)) & b[WIDTH-1];
  assign w_abs_a = w_sa ? -a : a;
  assign w_abs_b = w_sb ? -b : b;

  assign w_iter_done = (r_cnt == CNT_W'(WIDTH));
`ifdef MULDIV_EARLY_EXIT_EN
  assign w_mul_zero = (r_mplier == '0);
`else
  assign w_mul_zero = 1'b0;
`endif

  // Restoring divide step: shift in the next dividend bit, keep the trial if non-negative.
  assign w_shift    = {r_rem, r_quo[WIDTH-1]};
  assign w_diff     = w_shift - {1'b0, r_divisor};
  assign w_trial_ok = ~w_diff[WIDTH];

  assign w_raw = (r_op == OP_DIV || r_op == OP_DIVU) ? {r_rem, r_quo} : r_acc;

  muldiv_signfix #(.WIDTH(WIDTH)) u_signfix (
    .i_raw     (w_raw),
    .i_op      (r_op),
    .i_neg_res (r_neg_res),
    .i_neg_rem (r_neg_rem),
    .o_hi      (w_fix_hi),
    .o_lo      (w_fix_lo)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = op[1] ? S_DIV : S_MUL;
      S_MUL:   if (w_iter_done || w_mul_zero) w_next = S_FIX;
      S_DIV:   if (w_iter_done) w_next = S_FIX;
      S_FIX:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    if (flush) w_next = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_op      <= OP_MULT;
      r_cnt     <= '0;
      r_acc     <= '0;
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_rem     <= '0;
      r_quo     <= '0;
      r_divisor <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_neg_res <= 1'b0;
      r_neg_rem <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (hi_we) r_hi <= wdata;
          if (lo_we) r_lo <= wdata;
          if (start && !flush) begin
            r_op      <= op_e'(op);
            r_cnt     <= '0;
            r_acc     <= '0;
            r_mcand   <= {{WIDTH{1'b0}}, w_abs_a};
            r_mplier  <= w_abs_b;
            r_rem     <= '0;
            r_quo     <= w_abs_a;
            r_divisor <= w_abs_b;
            // A zero divisor keeps the all-ones quotient unsigned.
            r_neg_res <= (w_sa ^ w_sb) && !(op[1] && b == '0);
            r_neg_rem <= w_sa;
          end
        end
        S_MUL: begin
          if (!w_iter_done && !w_mul_zero) begin
            if (r_mplier[0]) r_acc <= r_acc + r_mcand;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + CNT_W'(1);
          end
        end
        S_DIV: begin
          if (!w_iter_done) begin
            r_rem <= w_trial_ok ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
            r_quo <= {r_quo[WIDTH-2:0], w_trial_ok};
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_FIX: begin
          if (!flush) begin
            r_hi <= w_fix_hi;
            r_lo <= w_fix_lo;
          end
        end
        default: ;
      endcase
    end
  end

  // Results are forwarded in the FIX cycle so consumers see them alongside done.
  assign busy = (r_state != S_IDLE);
  assign done = (r_state == S_FIX) && !flush;
  assign hi   = done ? w_fix_hi : r_hi;
  assign lo   = done ? w_fix_lo : r_lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: arithmetic reference model, decoupled done monitor.
// Expected multiply latency follows MULDIV_EARLY_EXIT_EN when it is defined.
module tb_muldiv_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         flush;
  logic         hiWe;
  logic         loWe;
  logic [W-1:0] wdata;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    int           lat;
    int           issue;
  } exp_t;

  exp_t sb[$];

  muldiv_unit #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .flush (flush),
    .hi_we (hiWe),
    .lo_we (loWe),
    .wdata (wdata),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic int bitLen(input logic [W-1:0] v);
    int n = 0;
    for (int i = 0; i < W; i++) if (v[i]) n = i + 1;
    return n;
  endfunction

  // HI/LO from plain 64-bit arithmetic; latency counted in busy cycles.
  function automatic exp_t refModel(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t e;
    longint sx, sy, q, r;
    logic [63:0] p;
    logic [W-1:0] mag;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    e.lat = W + 2;
    e.issue = 0;
    mag = y;
    if (o == 2'd0) begin
      p = sx * sy;
      e.hi = p[63:32];
      e.lo = p[31:0];
      if (y[W-1]) mag = -y;
    end else if (o == 2'd1) begin
      p = {32'b0, x} * {32'b0, y};
      e.hi = p[63:32];
      e.lo = p[31:0];
    end else if (y == '0) begin
      e.hi = x;
      e.lo = '1;
    end else if (o == 2'd2) begin
      q = sx / sy;
      r = sx % sy;
      e.hi = r[W-1:0];
      e.lo = q[W-1:0];
    end else begin
      e.hi = x % y;
      e.lo = x / y;
    end
`ifdef MULDIV_EARLY_EXIT_EN
    if (!o[1]) e.lat = 2 + bitLen(mag);
`endif
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic waitIdle();
    int n = 0;
    while (busy !== 1'b0 && n < 200) begin
      tick();
      n++;
    end
    if (busy !== 1'b0) checkOutput("idle_timeout", 64'(busy), 64'd0);
  endtask

  task automatic startRaw(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    op = o;
    a = x;
    b = y;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic applyStimulus(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t e;
    waitIdle();
    e = refModel(o, x, y);
    e.issue = cyc;
    sb.push_back(e);
    startRaw(o, x, y);
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (done === 1'b1) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL unexpected_done actual=1 required=0");
        end else begin
          e = sb.pop_front();
          checkOutput("hi", 64'(hi), 64'(e.hi));
          checkOutput("lo", 64'(lo), 64'(e.lo));
          checkOutput("latency", 64'(cyc - e.issue), 64'(e.lat));
          checkOutput("busy_in_fix", 64'(busy), 64'd1);
        end
      end
    end
  end

  initial begin
    exp_t e;
    logic [1:0]   ro;
    logic [W-1:0] rx, ry;
    rst = 1'b1; start = 1'b0; flush = 1'b0; hiWe = 1'b0; loWe = 1'b0;
    op = 2'd0; a = '0; b = '0; wdata = '0;
    repeat (3) tick();
    checkOutput("reset_busy", 64'(busy), 64'd0);
    checkOutput("reset_done", 64'(done), 64'd0);
    checkOutput("reset_hi", 64'(hi), 64'd0);
    checkOutput("reset_lo", 64'(lo), 64'd0);
    rst = 1'b0;
    tick();

    applyStimulus(2'd0, 32'hFFFFFFFE, 32'd3);
    applyStimulus(2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
    applyStimulus(2'd2, 32'hFFFFFFF9, 32'd2);
    applyStimulus(2'd3, 32'd7, 32'd0);
    applyStimulus(2'd2, 32'h80000000, 32'hFFFFFFFF);
    applyStimulus(2'd2, 32'hFFFFFFF9, 32'd0);
    applyStimulus(2'd1, 32'd5, 32'd1);
    applyStimulus(2'd0, 32'h12345678, 32'd0);
    waitIdle();

    hiWe = 1'b1; wdata = 32'h1234; tick();
    hiWe = 1'b0; loWe = 1'b1; wdata = 32'h5678; tick();
    loWe = 1'b0;
    checkOutput("mthi", 64'(hi), 64'h1234);
    checkOutput("mtlo", 64'(lo), 64'h5678);

    // Flush mid-divide with a competing start.
    startRaw(2'd2, 32'd100, 32'd7);
    repeat (8) tick();
    flush = 1'b1; start = 1'b1; op = 2'd3;
    tick();
    flush = 1'b0; start = 1'b0;
    checkOutput("flush_busy", 64'(busy), 64'd0);
    checkOutput("flush_hi", 64'(hi), 64'h1234);
    checkOutput("flush_lo", 64'(lo), 64'h5678);
    repeat (3) tick();
    checkOutput("flush_beats_start", 64'(busy), 64'd0);

    // Flush landing exactly in the FIX cycle.
    e = refModel(2'd1, 32'd3, 32'd4);
    startRaw(2'd1, 32'd3, 32'd4);
    repeat (e.lat - 1) tick();
    checkOutput("fix_cycle_busy", 64'(busy), 64'd1);
    flush = 1'b1;
    #1;
    checkOutput("fix_flush_done", 64'(done), 64'd0);
    tick();
    flush = 1'b0;
    checkOutput("fix_flush_busy", 64'(busy), 64'd0);
    checkOutput("fix_flush_hi", 64'(hi), 64'h1234);
    checkOutput("fix_flush_lo", 64'(lo), 64'h5678);

    // Start and MTLO while busy are both ignored.
    applyStimulus(2'd1, 32'd3, 32'd5);
    repeat (2) tick();
    start = 1'b1; op = 2'd1; a = 32'd7; b = 32'd7; loWe = 1'b1; wdata = 32'hA5A5A5A5;
    tick();
    start = 1'b0; loWe = 1'b0;
    checkOutput("mtlo_busy_ignored", 64'(lo), 64'h5678);
    waitIdle();
    repeat (40) tick();
    checkOutput("after_busy_lo", 64'(lo), 64'd15);
    checkOutput("after_busy_idle", 64'(busy), 64'd0);
    loWe = 1'b1; wdata = 32'hA5A5A5A5; tick();
    loWe = 1'b0;
    checkOutput("mtlo_idle", 64'(lo), 64'hA5A5A5A5);

    // MTLO together with start: write lands, then FIX overwrites it.
    loWe = 1'b1; wdata = 32'hDEADBEEF;
    applyStimulus(2'd1, 32'd6, 32'd7);
    loWe = 1'b0;
    checkOutput("mtlo_with_start", 64'(lo), 64'hDEADBEEF);
    waitIdle();
    checkOutput("start_overwrites_lo", 64'(lo), 64'd42);

    // Reset in the middle of a divide clears HI/LO.
    startRaw(2'd2, 32'd1000, 32'd3);
    repeat (5) tick();
    rst = 1'b1; tick(); rst = 1'b0;
    checkOutput("midop_rst_busy", 64'(busy), 64'd0);
    checkOutput("midop_rst_hi", 64'(hi), 64'd0);
    checkOutput("midop_rst_lo", 64'(lo), 64'd0);

    for (int i = 0; i < 24; i++) begin
      ro = 2'($urandom_range(0, 3));
      rx = $urandom;
      case ($urandom_range(0, 3))
        0:       ry = '0;
        1:       ry = W'($urandom_range(1, 255));
        2:       ry = -W'($urandom_range(1, 255));
        default: ry = $urandom;
      endcase
      applyStimulus(ro, rx, ry);
    end
    waitIdle();
    repeat (3) tick();
    checkOutput("scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multi-cycle multiply/divide sequencer in the EX stage. Executes MULT/MULTU/DIV/DIVU into architectural HI/LO registers.
- Performs one add/sub-and-shift step per cycle and raises busy so hazard logic stalls MFHI/MFLO and further mul/div issue.
- Also services MTHI/MTLO writes and flush aborts.

Parameters:
- WIDTH, 32, operand/HI/LO width. Iteration count equals WIDTH.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous active-high reset
- start  in  1  issue request; sampled only in IDLE
- op  in  2  0=MULT 1=MULTU 2=DIV 3=DIVU
- a  in  WIDTH  rs operand (multiplicand / dividend)
- b  in  WIDTH  rt operand (multiplier / divisor)
- flush  in  1  abort in-flight operation
- hi_we  in  1  MTHI write enable
- lo_we  in  1  MTLO write enable
- wdata  in  WIDTH  MTHI/MTLO data
- busy  out  1  operation in flight
- done  out  1  one-cycle pulse when HI/LO updated by mul/div
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register

Behaviour:
- Interface: one clock; reset is synchronous and active-high. Ports are clk and rst.
- Reset: state=IDLE, busy=0, done=0, hi=0, lo=0, counter=0.
- FSM states:
  - IDLE: start=1 latches op and the absolute values of a, b (signed ops only), plus the sign flags. Next state is MUL (op 0/1) or DIV (op 2/3).
  - MUL: radix-2 shift-add over a 2*WIDTH accumulator, one multiplier bit per cycle, WIDTH cycles.
  - DIV: restoring divide; shift remainder/quotient, trial subtract, WIDTH cycles.
  - FIX: apply sign correction, write hi/lo, pulse done, return to IDLE.
- Latency: start sampled at edge N; busy=1 from N+1 through the FIX cycle; done=1 and hi/lo valid for the cycle after edge N+WIDTH+1 (34 cycles for WIDTH=32). busy and done are both high in the FIX cycle.
- Sign rules:
  - MULT: 64-bit product negated when the operand signs differ.
  - DIV: quotient negated when signs differ; remainder takes the sign of the dividend.
  - Results: HI=upper/remainder, LO=lower/quotient.
- Divide by zero: no trap. HI=a, LO=all ones, still full latency.
- Overflow case 0x80000000 / 0xFFFFFFFF signed: LO=0x80000000, HI=0 (unsigned-magnitude wrap); no special path.
- start while busy: ignored, no queueing. Pipeline must stall.
- hi_we/lo_we in IDLE: write wdata the next edge. If start is also high, the write applies but is overwritten at FIX. While busy, writes are ignored.
- flush: any state goes to IDLE next edge. busy=0, done=0, hi/lo unchanged. flush wins over simultaneous start. flush in the FIX cycle still suppresses the hi/lo update.
- rst mid-operation: same as reset; hi/lo cleared.

Optional Feature:
- Macro MULDIV_EARLY_EXIT_EN.
- Defined: MUL exits to FIX as soon as the remaining unshifted multiplier bits are all zero. Latency becomes 2 + (index of highest set bit of |b|)+1. b=0 takes 2 cycles to done.
- Undefined: fixed WIDTH+2 latency for all ops. DIV is always fixed-latency either way.

Decomposition:
- Package muldiv_pkg:
  - op_e enum (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU)
  - state_e enum (S_IDLE, S_MUL, S_DIV, S_FIX)
  - localparam CNT_W = $clog2(WIDTH)+1
- One combinational sub-module, muldiv_signfix: takes raw 2*WIDTH result, op, and sign flags; returns corrected {hi,lo}. Shared by FIX for both mul and div.

Test Plan:
- MULT a=0xFFFFFFFE (-2), b=3 -> done at cycle 34; HI=0xFFFFFFFF, LO=0xFFFFFFFA; busy high cycles 1..34.
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
- DIV a=-7 (0xFFFFFFF9), b=2 -> LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1). DIVU a=7, b=0 -> HI=7, LO=0xFFFFFFFF.
- Start DIV, assert flush at cycle 10 with a simultaneous start -> busy=0 at cycle 11, no done pulse, HI/LO keep prior values (0x1234/0x5678 preloaded via MTHI/MTLO).
- MTLO wdata=0xA5A5A5A5 while busy -> ignored; repeated in IDLE -> lo=0xA5A5A5A5 next cycle. Start during busy -> no second operation.
- With MULDIV_EARLY_EXIT_EN: MULTU a=5, b=1 -> done 3 cycles after start, LO=5. Without the macro: done at 34.
